// File: rtl/prbs31_pkg.sv
// Shared constants and types for the PRBS31 (x^31 + x^28 + 1) checker and generator.
package prbs31_pkg;

    localparam int unsigned PrbsLen = 31;
    localparam int unsigned TapHi   = 30;
    localparam int unsigned TapLo   = 27;

    typedef logic [PrbsLen-1:0] sr_t;

    typedef enum logic [1:0] {
        StSeed   = 2'd0,
        StCheck  = 2'd1,
        StLocked = 2'd2
    } state_e;

    // Seed counter value on the last of the PrbsLen seeding bits.
    localparam logic [4:0] SeedLast = 5'(PrbsLen - 1);

endpackage

// File: rtl/prbs31_lfsr_step.sv
// One step of the PRBS31 shift register: predicted next bit and shifted register contents.
module prbs31_lfsr_step
    import prbs31_pkg::*;
(
    input  sr_t  sr_i,
    input  logic shift_bit_i,
    output logic pred_o,
    output sr_t  sr_next_o
);

    always_comb begin
        pred_o    = sr_i[TapHi] ^ sr_i[TapLo];
        sr_next_o = {sr_i[PrbsLen-2:0], shift_bit_i};
    end

endmodule

// File: rtl/prbs31_checker.sv
// PRBS31 stream checker: seeds from the incoming stream, verifies it, then free-runs while
// locked and counts bit errors, dropping lock when too many errors land in one window.
module prbs31_checker
    import prbs31_pkg::*;
#(
    parameter int unsigned LOCK_CNT  = 64,
    parameter int unsigned LOSS_ERRS = 8,
    parameter int unsigned WINDOW    = 256,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_in,
    input  logic             data_valid,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       state
);

    localparam int unsigned MatchW = $clog2(LOCK_CNT + 1);
    localparam int unsigned WinW   = $clog2(WINDOW + 1);
    localparam int unsigned WerrW  = $clog2(LOSS_ERRS + 1);

    localparam logic [MatchW-1:0] MatchLast = MatchW'(LOCK_CNT - 1);
    localparam logic [WinW-1:0]   WinLast   = WinW'(WINDOW - 1);
    localparam logic [WerrW-1:0]  WerrLoss  = WerrW'(LOSS_ERRS);

    state_e            state_q, state_d;
    sr_t               sr_q, sr_d;
    logic [4:0]        seed_cnt_q, seed_cnt_d;
    logic [MatchW-1:0] match_cnt_q, match_cnt_d;
    logic [WinW-1:0]   win_cnt_q, win_cnt_d;
    logic [WerrW-1:0]  win_err_q, win_err_d;
    logic [CNT_W-1:0]  err_count_q, err_count_d;
    logic              err_pulse_q, err_pulse_d;
    logic              locked_q, locked_d;

    logic              pred_bit;
    logic              shift_bit;
    sr_t               sr_next;
    logic              bit_err;
    logic [WerrW-1:0]  win_err_nxt;

    // Once locked the register free-runs on its own prediction so a corrupted bit
    // cannot poison later predictions.
    assign shift_bit = (state_q == StLocked) ? pred_bit : data_in;

    prbs31_lfsr_step u_step (
        .sr_i        (sr_q),
        .shift_bit_i (shift_bit),
        .pred_o      (pred_bit),
        .sr_next_o   (sr_next)
    );

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        seed_cnt_d  = seed_cnt_q;
        match_cnt_d = match_cnt_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        err_count_d = err_count_q;
        err_pulse_d = 1'b0;
        bit_err     = 1'b0;
        win_err_nxt = win_err_q;

        if (data_valid) begin
            unique case (state_q)
                StSeed: begin
                    sr_d = sr_next;
                    if (seed_cnt_q == SeedLast) begin
                        seed_cnt_d = '0;
                        // An all-zero seed would predict zeros forever; reseed instead.
                        if (sr_next != '0) begin
                            state_d     = StCheck;
                            match_cnt_d = '0;
                        end
                    end else begin
                        seed_cnt_d = seed_cnt_q + 5'd1;
                    end
                end
                StCheck: begin
                    sr_d = sr_next;
                    if (data_in == pred_bit) begin
                        if (match_cnt_q == MatchLast) begin
                            state_d   = StLocked;
                            win_cnt_d = '0;
                            win_err_d = '0;
                        end else begin
                            match_cnt_d = match_cnt_q + MatchW'(1);
                        end
                    end else begin
                        state_d    = StSeed;
                        seed_cnt_d = '0;
                    end
                end
                StLocked: begin
                    sr_d        = sr_next;
                    bit_err     = (data_in != pred_bit);
                    err_pulse_d = bit_err;
                    if (bit_err && (err_count_q != '1)) begin
                        err_count_d = err_count_q + CNT_W'(1);
                    end
                    // The bit that wraps the window is the first bit of the new window.
                    if (win_cnt_q == WinLast) begin
                        win_cnt_d   = '0;
                        win_err_nxt = WerrW'(bit_err);
                    end else begin
                        win_cnt_d   = win_cnt_q + WinW'(1);
                        win_err_nxt = win_err_q + WerrW'(bit_err);
                    end
                    win_err_d = win_err_nxt;
                    if (win_err_nxt == WerrLoss) begin
                        state_d    = StSeed;
                        seed_cnt_d = '0;
                        win_cnt_d  = '0;
                        win_err_d  = '0;
                    end
                end
                default: begin
                    state_d    = StSeed;
                    seed_cnt_d = '0;
                end
            endcase
        end

        if (clear_cnt) begin
            err_count_d = '0;
        end

        locked_d = (state_d == StLocked);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StSeed;
            sr_q        <= '0;
            seed_cnt_q  <= '0;
            match_cnt_q <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            err_count_q <= '0;
            err_pulse_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            seed_cnt_q  <= seed_cnt_d;
            match_cnt_q <= match_cnt_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            err_count_q <= err_count_d;
            err_pulse_q <= err_pulse_d;
            locked_q    <= locked_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign state     = state_q;

endmodule

// File: tb/tb_prbs31_checker.sv
// Scoreboard bench for prbs31_checker: two instances (default, and CNT_W=4/LOSS_ERRS=1000)
// share one stimulus stream and are compared against a bit-history reference model.
module tb_prbs31_checker;

    localparam int LockCnt = 64;
    localparam int Window  = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_in;
    logic        data_valid;
    logic        clear_cnt;

    logic        locked0, pulse0;
    logic [15:0] cnt0;
    logic [1:0]  state0;
    logic        locked1, pulse1;
    logic [3:0]  cnt1;
    logic [1:0]  state1;

    always #5 clk = ~clk;

    prbs31_checker dut0 (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .clear_cnt  (clear_cnt),
        .locked     (locked0),
        .err_pulse  (pulse0),
        .err_count  (cnt0),
        .state      (state0)
    );

    prbs31_checker #(
        .CNT_W     (4),
        .LOSS_ERRS (1000)
    ) dut1 (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .clear_cnt  (clear_cnt),
        .locked     (locked1),
        .err_pulse  (pulse1),
        .err_count  (cnt1),
        .state      (state1)
    );

    typedef struct {
        bit locked;
        bit pulse;
        int cnt;
        int state;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;

    // Reference model: per instance, a history of the bits the checker believes in.
    int m_mode  [2];
    int m_match [2];
    int m_lbit  [2];
    int m_werr  [2];
    int m_cnt   [2];
    int m_len   [2];
    bit m_hist  [2][64];
    int p_loss  [2];
    int p_cmax  [2];

    bit g_hist[$];

    task automatic hpush(input int i, input bit b);
        if (m_len[i] == 64) begin
            for (int k = 0; k < 31; k++) m_hist[i][k] = m_hist[i][k+33];
            m_len[i] = 31;
        end
        m_hist[i][m_len[i]] = b;
        m_len[i]++;
    endtask

    function automatic bit hpred(input int i);
        return m_hist[i][m_len[i]-31] ^ m_hist[i][m_len[i]-28];
    endfunction

    task automatic model_step(input int i, input bit r, input bit v, input bit d, input bit c,
                              output exp_t e);
        bit pred;
        bit err;
        bit allz;
        err = 1'b0;
        if (r) begin
            m_mode[i] = 0; m_len[i] = 0; m_match[i] = 0;
            m_lbit[i] = 0; m_werr[i] = 0; m_cnt[i] = 0;
        end else begin
            if (v) begin
                if (m_mode[i] == 0) begin
                    hpush(i, d);
                    if (m_len[i] == 31) begin
                        allz = 1'b1;
                        for (int k = 0; k < 31; k++) if (m_hist[i][k]) allz = 1'b0;
                        if (allz) m_len[i] = 0;
                        else begin
                            m_mode[i]  = 1;
                            m_match[i] = 0;
                        end
                    end
                end else if (m_mode[i] == 1) begin
                    pred = hpred(i);
                    hpush(i, d);
                    if (d == pred) begin
                        m_match[i]++;
                        if (m_match[i] == LockCnt) begin
                            m_mode[i] = 2; m_lbit[i] = 0; m_werr[i] = 0;
                        end
                    end else begin
                        m_mode[i] = 0;
                        m_len[i]  = 0;
                    end
                end else begin
                    pred = hpred(i);
                    hpush(i, pred);
                    err = (d != pred);
                    // Windows are aligned so that locked bit index i starts one when (i+1)%W==0.
                    if ((m_lbit[i] + 1) % Window == 0) m_werr[i] = 0;
                    m_lbit[i]++;
                    if (err) begin
                        m_werr[i]++;
                        if (m_cnt[i] < p_cmax[i]) m_cnt[i]++;
                    end
                    if (m_werr[i] == p_loss[i]) begin
                        m_mode[i] = 0;
                        m_len[i]  = 0;
                    end
                end
            end
            if (c) m_cnt[i] = 0;
        end
        e.locked = (m_mode[i] == 2);
        e.pulse  = err;
        e.cnt    = m_cnt[i];
        e.state  = m_mode[i];
    endtask

    task automatic gen_reset();
        g_hist.delete();
        for (int i = 0; i < 31; i++) g_hist.push_back(i == 30);
    endtask

    task automatic gen_next(output bit b);
        b = g_hist[0] ^ g_hist[3];
        g_hist.push_back(b);
        void'(g_hist.pop_front());
    endtask

    task automatic dcheck(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cmp_out(input string nm, input exp_t e, input logic l, input logic p,
                           input int c, input logic [1:0] s);
        checks++;
        if (l !== e.locked || p !== e.pulse || c != e.cnt || int'(s) != e.state) begin
            errors++;
            $display("FAIL %s @%0t: got locked=%b pulse=%b cnt=%0d state=%0d expected locked=%0d pulse=%0d cnt=%0d state=%0d",
                     nm, $time, l, p, c, s, e.locked, e.pulse, e.cnt, e.state);
        end
    endtask

    // Monitor: compares every registered output set against the queued expectation.
    initial begin
        exp_t e0;
        exp_t e1;
        forever begin
            @(posedge clk);
            #2;
            if (q0.size() > 0 && q1.size() > 0) begin
                e0 = q0.pop_front();
                e1 = q1.pop_front();
                cmp_out("dut0_outputs", e0, locked0, pulse0, int'(cnt0), state0);
                cmp_out("dut1_outputs", e1, locked1, pulse1, int'(cnt1), state1);
            end
        end
    end

    task automatic cycle(input bit r, input bit v, input bit flip, input bit c, input bit z);
        exp_t e0;
        exp_t e1;
        bit   d;
        @(negedge clk);
        if (z) d = 1'b0;
        else if (v) begin
            gen_next(d);
            d = d ^ flip;
        end else d = 1'($urandom_range(0, 1));
        rst        = r;
        data_valid = v;
        data_in    = d;
        clear_cnt  = c;
        model_step(0, r, v, d, c, e0);
        model_step(1, r, v, d, c, e1);
        q0.push_back(e0);
        q1.push_back(e1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        gen_reset();
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_until_lock(input int budget, input bit toggle, output int nvalid);
        bit got;
        bit v;
        got    = 1'b0;
        nvalid = 0;
        for (int k = 0; k < budget && !got; k++) begin
            v = toggle ? (k % 2 == 0) : 1'b1;
            cycle(1'b0, v, 1'b0, 1'b0, 1'b0);
            if (v) nvalid++;
            else if (toggle) dcheck("no_pulse_when_invalid", int'(pulse0), 0);
            if (locked0 === 1'b1) got = 1'b1;
        end
        if (!got) nvalid = -1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n;
        bit  saw;
        bit  v, f, c, r;
        rst        = 1'b1;
        data_valid = 1'b0;
        data_in    = 1'b0;
        clear_cnt  = 1'b0;
        p_loss[0] = 8;    p_cmax[0] = 65535;
        p_loss[1] = 1000; p_cmax[1] = 15;
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_match[i] = 0; m_lbit[i] = 0;
            m_werr[i] = 0; m_cnt[i] = 0; m_len[i] = 0;
        end

        // Reset state and first lock on a continuous stream.
        do_reset();
        dcheck("reset_state", int'(state0), 0);
        dcheck("reset_locked", int'(locked0), 0);
        dcheck("reset_err_count", int'(cnt0), 0);
        run_until_lock(300, 1'b0, n);
        dcheck("lock_after_valid_bits", n, 95);
        dcheck("lock_err_count", int'(cnt0), 0);
        dcheck("lock_state", int'(state0), 2);

        // Single inverted bit while locked.
        repeat (20) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        dcheck("single_err_pulse", int'(pulse0), 1);
        dcheck("single_err_count", int'(cnt0), 1);
        dcheck("single_err_locked", int'(locked0), 1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        dcheck("single_err_pulse_drops", int'(pulse0), 0);
        repeat (30) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        dcheck("single_err_count_held", int'(cnt0), 1);

        // Eight errors inside one window drop lock, then relock.
        do_reset();
        run_until_lock(300, 1'b0, n);
        dcheck("lock_before_loss", n, 95);
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            if (k < 7) repeat (9) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        dcheck("loss_locked", int'(locked0), 0);
        dcheck("loss_state", int'(state0), 0);
        dcheck("loss_err_count", int'(cnt0), 8);
        dcheck("loss_err_pulse", int'(pulse0), 1);
        dcheck("no_loss_big_threshold", int'(locked1), 1);
        run_until_lock(300, 1'b0, n);
        dcheck("relock_valid_bits", n, 95);

        // Valid toggling every cycle.
        do_reset();
        run_until_lock(400, 1'b1, n);
        dcheck("toggle_lock_valid_bits", n, 95);

        // Saturation and clear-vs-error priority on the 4-bit counter instance.
        do_reset();
        run_until_lock(300, 1'b0, n);
        for (int k = 0; k < 20; k++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            repeat (2) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        dcheck("sat_err_count", int'(cnt1), 15);
        dcheck("sat_locked", int'(locked1), 1);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        dcheck("clear_priority_count", int'(cnt1), 0);
        dcheck("clear_priority_pulse", int'(pulse1), 1);

        // Reset while locked with errors accumulated.
        do_reset();
        run_until_lock(300, 1'b0, n);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            repeat (20) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        dcheck("pre_reset_err_count", int'(cnt0), 5);
        dcheck("pre_reset_locked", int'(locked0), 1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        dcheck("mid_lock_reset_locked", int'(locked0), 0);
        dcheck("mid_lock_reset_count", int'(cnt0), 0);
        dcheck("mid_lock_reset_state", int'(state0), 0);

        // All-zero input must never lock.
        do_reset();
        saw = 1'b0;
        repeat (300) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
            if (locked0 !== 1'b0) saw = 1'b1;
        end
        dcheck("zeros_never_lock", int'(saw), 0);
        dcheck("zeros_state", int'(state0), 0);

        // Randomized traffic: gaps, sparse bit errors, clears and occasional resets.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            r = ($urandom_range(0, 1499) == 0);
            v = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 59) == 0);
            c = ($urandom_range(0, 149) == 0);
            cycle(r, v, f, c, 1'b0);
        end

        repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #5;
        dcheck("scoreboard_drained", q0.size() + q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
